// File: rtl/redmule_pkg.sv
// Shared types and constants for the RedMulE load/store request scheduler.
// Latency: n/a (types, constants and a combinational round-robin helper only).
// Backpressure: n/a.
package redmule_pkg;

  localparam int unsigned XsourceStreamId  = 0;
  localparam int unsigned WsourceStreamId  = 1;
  localparam int unsigned YsourceStreamId  = 2;
  localparam int unsigned NumStreamSources = 3;
  localparam int unsigned LdstOutstanding  = 4;

  // Channel selector; load ids match the stream source ids, Z is the store sink.
  typedef enum logic [1:0] {
    SEL_X = 2'd0,
    SEL_W = 2'd1,
    SEL_Y = 2'd2,
    SEL_Z = 2'd3
  } ldst_sel_e;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } ldst_state_e;

  // First asserted load request at or after ptr, wrapping over the three sources.
  function automatic logic [1:0] rr_pick(input logic [2:0] req, input logic [1:0] ptr);
    logic [1:0] res;
    logic [1:0] idx;
    logic       found;
    res   = ptr;
    found = 1'b0;
    for (int off = 0; off < 3; off++) begin
      idx = 2'((32'(ptr) + 32'(off)) % 3);
      if (!found && req[idx]) begin
        res   = idx;
        found = 1'b1;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/redmule_ldst_scheduler_if.sv
// Handshake bundle between the streamer channels, the TCDM initiator and the scheduler.
// Latency: n/a (wires only).
// Backpressure: carries the HCI req/gnt pair; requesters hold req until granted.
interface redmule_ldst_scheduler_if
  import redmule_pkg::*;
#(
  parameter int unsigned NumLoad = NumStreamSources
);
  logic [NumLoad-1:0] load_req_i;
  logic [NumLoad-1:0] load_gnt_o;
  logic               store_req_i;
  logic               store_gnt_o;
  logic               tcdm_req_o;
  logic               tcdm_gnt_i;
  logic               tcdm_wen_o;
  logic [1:0]         sel_o;
  logic               tcdm_r_valid_i;
  logic [NumLoad-1:0] load_r_valid_o;
  logic               store_r_valid_o;
  logic               busy_o;
  logic               rsp_err_o;

  modport slave (
    input  load_req_i, store_req_i, tcdm_gnt_i, tcdm_r_valid_i,
    output load_gnt_o, store_gnt_o, tcdm_req_o, tcdm_wen_o, sel_o,
           load_r_valid_o, store_r_valid_o, busy_o, rsp_err_o
  );

  modport master (
    output load_req_i, store_req_i, tcdm_gnt_i, tcdm_r_valid_i,
    input  load_gnt_o, store_gnt_o, tcdm_req_o, tcdm_wen_o, sel_o,
           load_r_valid_o, store_r_valid_o, busy_o, rsp_err_o
  );
endinterface

// File: rtl/redmule_ldst_rsp_fifo.sv
// Circular FIFO of 2-bit channel ids for in-flight TCDM transactions.
// Latency: head visible the cycle after push; count updates on the clock edge.
// Backpressure: push ignored when full, pop ignored when empty; push+pop keeps count.
module redmule_ldst_rsp_fifo #(
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned AW    = $clog2(DEPTH),
  localparam int unsigned CW    = AW + 1
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          clear_i,
  input  logic          push_i,
  input  logic [1:0]    data_i,
  input  logic          pop_i,
  output logic [1:0]    data_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [CW-1:0] count_o
);

  logic [1:0]    mem_q [DEPTH];
  logic [1:0]    mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          push_ok, pop_ok;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign data_o  = mem_q[rd_ptr_q];
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;

  // Pointer, count and storage update; pointers wrap naturally at the power-of-two depth.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) begin
        mem_d[wr_ptr_q] = data_i;
        wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      count_d = count_q + CW'(push_ok) - CW'(pop_ok);
    end
  end

  // State registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/redmule_ldst_scheduler.sv
// Arbitrates X/W/Y loads and Z stores onto one TCDM port; routes in-order responses by id.
// Latency: 0-cycle req->tcdm_req/sel path; responses routed combinationally from the id FIFO head.
// Backpressure: selection locked across gnt stalls; no issue at OUTSTANDING in flight. Optional counters: REDMULE_LDST_SCHED_PERF_EN.
module redmule_ldst_scheduler
  import redmule_pkg::*;
#(
  parameter int unsigned OUTSTANDING = LdstOutstanding,
  parameter int unsigned NumLoad     = NumStreamSources
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     clear_i,
  input  logic                     enable_i,
  redmule_ldst_scheduler_if.slave  bus
`ifdef REDMULE_LDST_SCHED_PERF_EN
  ,
  output logic [31:0]              perf_stall_o,
  output logic [31:0]              perf_full_o
`endif
);

  localparam int unsigned CW = $clog2(OUTSTANDING) + 1;

  ldst_state_e   state_q, state_d;
  ldst_sel_e     lock_sel_q, lock_sel_d;
  logic [1:0]    rr_ptr_q, rr_ptr_d;
  logic          last_was_store_q, last_was_store_d;
  logic          rsp_err_q, rsp_err_d;

  ldst_sel_e     sel;
  logic          req, hs, load_any, eligible;
  logic [1:0]    rr_idx;
  logic [1:0]    head;
  logic          full, empty, pop;
  logic [CW-1:0] count;

  assign load_any = |bus.load_req_i;
  assign rr_idx   = rr_pick(bus.load_req_i, rr_ptr_q);
  assign eligible = enable_i && !full;

  // Request selection: a locked transaction wins; otherwise class arbitration then load round-robin.
  always_comb begin
    req = 1'b0;
    sel = SEL_X;
    if (state_q == ST_LOCKED) begin
      req = 1'b1;
      sel = lock_sel_q;
    end else if (eligible && (load_any || bus.store_req_i)) begin
      req = 1'b1;
      if (bus.store_req_i && (!load_any || !last_was_store_q)) sel = SEL_Z;
      else                                                     sel = ldst_sel_e'(rr_idx);
    end
  end

  assign hs = req && bus.tcdm_gnt_i;

  // Grant fan-out and response routing from the id FIFO head.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      bus.load_gnt_o[i]     = hs && (sel == ldst_sel_e'(2'(i)));
      bus.load_r_valid_o[i] = pop && (head == 2'(i));
    end
  end

  assign pop                 = bus.tcdm_r_valid_i && !empty;
  assign bus.store_gnt_o     = hs && (sel == SEL_Z);
  assign bus.store_r_valid_o = pop && (head == SEL_Z);
  assign bus.tcdm_req_o      = req;
  assign bus.tcdm_wen_o      = req && (sel != SEL_Z);
  assign bus.sel_o           = sel;
  assign bus.busy_o          = (count != '0) || (state_q == ST_LOCKED);
  assign bus.rsp_err_o       = rsp_err_q;

  // Next-state: lock on ungranted request, release on grant; clear returns everything to idle.
  always_comb begin
    state_d          = state_q;
    lock_sel_d       = lock_sel_q;
    rr_ptr_d         = rr_ptr_q;
    last_was_store_d = last_was_store_q;
    rsp_err_d        = rsp_err_q;
    if (clear_i) begin
      state_d          = ST_IDLE;
      lock_sel_d       = SEL_X;
      rr_ptr_d         = '0;
      last_was_store_d = 1'b0;
      rsp_err_d        = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE:   if (req && !bus.tcdm_gnt_i) begin
                     state_d    = ST_LOCKED;
                     lock_sel_d = sel;
                   end
        ST_LOCKED: if (bus.tcdm_gnt_i) state_d = ST_IDLE;
        default:   state_d = ST_IDLE;
      endcase
      if (hs) begin
        last_was_store_d = (sel == SEL_Z);
        if (sel != SEL_Z) rr_ptr_d = (sel == SEL_Y) ? 2'd0 : 2'(sel) + 2'd1;
      end
      if (bus.tcdm_r_valid_i && empty) rsp_err_d = 1'b1;
    end
  end

  // State registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q          <= ST_IDLE;
      lock_sel_q       <= SEL_X;
      rr_ptr_q         <= '0;
      last_was_store_q <= 1'b0;
      rsp_err_q        <= 1'b0;
    end else begin
      state_q          <= state_d;
      lock_sel_q       <= lock_sel_d;
      rr_ptr_q         <= rr_ptr_d;
      last_was_store_q <= last_was_store_d;
      rsp_err_q        <= rsp_err_d;
    end
  end

  redmule_ldst_rsp_fifo #(
    .DEPTH (OUTSTANDING)
  ) i_rsp_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .clear_i (clear_i),
    .push_i  (hs),
    .data_i  (sel),
    .pop_i   (pop),
    .data_o  (head),
    .full_o  (full),
    .empty_o (empty),
    .count_o (count)
  );

`ifdef REDMULE_LDST_SCHED_PERF_EN
  logic [31:0] perf_stall_q, perf_stall_d;
  logic [31:0] perf_full_q, perf_full_d;

  // Saturating stall and full-blocked cycle counters.
  always_comb begin
    perf_stall_d = perf_stall_q;
    perf_full_d  = perf_full_q;
    if (clear_i) begin
      perf_stall_d = '0;
      perf_full_d  = '0;
    end else begin
      if ((state_q == ST_LOCKED) && (perf_stall_q != '1)) perf_stall_d = perf_stall_q + 32'd1;
      if ((state_q == ST_IDLE) && enable_i && full && (load_any || bus.store_req_i) &&
          (perf_full_q != '1)) perf_full_d = perf_full_q + 32'd1;
    end
  end

  // Counter registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      perf_stall_q <= '0;
      perf_full_q  <= '0;
    end else begin
      perf_stall_q <= perf_stall_d;
      perf_full_q  <= perf_full_d;
    end
  end

  assign perf_stall_o = perf_stall_q;
  assign perf_full_o  = perf_full_q;
`endif

endmodule

// File: tb/tb_redmule_ldst_scheduler.sv
// Directed bench for redmule_ldst_scheduler: arbitration order, lock, outstanding limit, routing, reset.
module tb_redmule_ldst_scheduler;

  logic clk;
  logic rst_n;
  logic clear;
  logic enable;
  int   errors = 0;
  int   checks = 0;

  redmule_ldst_scheduler_if bus_if ();

`ifdef REDMULE_LDST_SCHED_PERF_EN
  logic [31:0] perf_stall;
  logic [31:0] perf_full;
`endif

  redmule_ldst_scheduler #(
    .OUTSTANDING (4)
  ) dut (
    .clk_i    (clk),
    .rst_ni   (rst_n),
    .clear_i  (clear),
    .enable_i (enable),
    .bus      (bus_if)
`ifdef REDMULE_LDST_SCHED_PERF_EN
    ,
    .perf_stall_o (perf_stall),
    .perf_full_o  (perf_full)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus_if.load_req_i     = 3'b000;
    bus_if.store_req_i    = 1'b0;
    bus_if.tcdm_gnt_i     = 1'b0;
    bus_if.tcdm_r_valid_i = 1'b0;
  endtask

  task automatic do_clear();
    idle_inputs();
    clear = 1'b1;
    cyc();
    clear = 1'b0;
  endtask

  task automatic test_reset();
    logic [9:0] outs;
    @(negedge clk);
    outs = {bus_if.tcdm_req_o, bus_if.tcdm_wen_o, bus_if.sel_o, bus_if.load_gnt_o,
            bus_if.store_gnt_o, bus_if.busy_o, bus_if.rsp_err_o};
    checks++;
    if (outs !== 10'b0) begin errors++; $display("FAIL reset_outputs: got %b expected %b", outs, 10'b0); end
    @(posedge clk);
    #1 rst_n = 1'b1;
    enable = 1'b1;
    @(negedge clk);
    checks++;
    if (bus_if.busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", bus_if.busy_o); end
    cyc();
  endtask

  task automatic test_rr_loads();
    logic [1:0] exp_sel [4];
    exp_sel = '{2'd0, 2'd2, 2'd0, 2'd2};
    do_clear();
    bus_if.load_req_i = 3'b101;
    bus_if.tcdm_gnt_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (bus_if.sel_o !== exp_sel[i]) begin errors++; $display("FAIL rr_sel[%0d]: got %0d expected %0d", i, bus_if.sel_o, exp_sel[i]); end
      checks++;
      if (bus_if.load_gnt_o !== (3'b001 << exp_sel[i]) || bus_if.tcdm_wen_o !== 1'b1) begin
        errors++; $display("FAIL rr_gnt[%0d]: got gnt=%b wen=%b expected gnt=%b wen=1", i, bus_if.load_gnt_o, bus_if.tcdm_wen_o, 3'b001 << exp_sel[i]);
      end
      cyc();
    end
  endtask

  task automatic test_class_arb();
    logic [1:0] exp_sel [6];
    logic [2:0] exp_lg;
    exp_sel = '{2'd3, 2'd0, 2'd3, 2'd1, 2'd3, 2'd2};
    do_clear();
    bus_if.load_req_i  = 3'b111;
    bus_if.store_req_i = 1'b1;
    bus_if.tcdm_gnt_i  = 1'b1;
    for (int i = 0; i < 6; i++) begin
      bus_if.tcdm_r_valid_i = (i > 0);
      @(negedge clk);
      exp_lg = (exp_sel[i] == 2'd3) ? 3'b000 : (3'b001 << exp_sel[i]);
      checks++;
      if (bus_if.sel_o !== exp_sel[i]) begin errors++; $display("FAIL arb_sel[%0d]: got %0d expected %0d", i, bus_if.sel_o, exp_sel[i]); end
      checks++;
      if (bus_if.load_gnt_o !== exp_lg || bus_if.store_gnt_o !== (exp_sel[i] == 2'd3)) begin
        errors++; $display("FAIL arb_gnt[%0d]: got load=%b store=%b expected load=%b store=%b", i, bus_if.load_gnt_o, bus_if.store_gnt_o, exp_lg, exp_sel[i] == 2'd3);
      end
      cyc();
    end
    idle_inputs();
    @(negedge clk);
    checks++;
    if (bus_if.rsp_err_o !== 1'b0) begin errors++; $display("FAIL arb_no_err: got %b expected 0", bus_if.rsp_err_o); end
    cyc();
  endtask

  task automatic test_lock();
    do_clear();
    bus_if.load_req_i = 3'b010;
    bus_if.tcdm_gnt_i = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      if (c == 2) bus_if.load_req_i = 3'b011;
      enable = (c != 3);
      @(negedge clk);
      checks++;
      if (bus_if.sel_o !== 2'd1 || bus_if.tcdm_req_o !== 1'b1 || bus_if.load_gnt_o !== 3'b000) begin
        errors++; $display("FAIL lock_hold[c%0d]: got sel=%0d req=%b gnt=%b expected sel=1 req=1 gnt=000", c, bus_if.sel_o, bus_if.tcdm_req_o, bus_if.load_gnt_o);
      end
      cyc();
    end
    enable = 1'b1;
    bus_if.tcdm_gnt_i = 1'b1;
    @(negedge clk);
    checks++;
    if (bus_if.sel_o !== 2'd1 || bus_if.load_gnt_o !== 3'b010) begin
      errors++; $display("FAIL lock_release_w: got sel=%0d gnt=%b expected sel=1 gnt=010", bus_if.sel_o, bus_if.load_gnt_o);
    end
    cyc();
    bus_if.load_req_i = 3'b001;
    @(negedge clk);
    checks++;
    if (bus_if.sel_o !== 2'd0 || bus_if.load_gnt_o !== 3'b001) begin
      errors++; $display("FAIL lock_next_x: got sel=%0d gnt=%b expected sel=0 gnt=001", bus_if.sel_o, bus_if.load_gnt_o);
    end
    cyc();
    idle_inputs();
    @(negedge clk);
    checks++;
    if (bus_if.busy_o !== 1'b1) begin errors++; $display("FAIL lock_busy: got %b expected 1", bus_if.busy_o); end
    cyc();
  endtask

  task automatic test_outstanding();
    int hs_cnt = 0;
    do_clear();
    bus_if.load_req_i = 3'b001;
    bus_if.tcdm_gnt_i = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (bus_if.tcdm_req_o && bus_if.tcdm_gnt_i) hs_cnt++;
      cyc();
    end
    checks++;
    if (hs_cnt != 4) begin errors++; $display("FAIL out_handshakes: got %0d expected 4", hs_cnt); end
    bus_if.tcdm_r_valid_i = 1'b1;
    @(negedge clk);
    checks++;
    if (bus_if.tcdm_req_o !== 1'b0 || bus_if.load_r_valid_o !== 3'b001) begin
      errors++; $display("FAIL out_full_pop: got req=%b rv=%b expected req=0 rv=001", bus_if.tcdm_req_o, bus_if.load_r_valid_o);
    end
    cyc();
    bus_if.tcdm_r_valid_i = 1'b0;
    @(negedge clk);
    checks++;
    if (bus_if.tcdm_req_o !== 1'b1) begin errors++; $display("FAIL out_reissue: got %b expected 1", bus_if.tcdm_req_o); end
    cyc();
  endtask

  task automatic test_rsp_routing();
    logic [3:0] exp_rv [3];
    logic [3:0] got;
    exp_rv = '{4'b0001, 4'b1000, 4'b0100};
    do_clear();
    bus_if.tcdm_gnt_i = 1'b1;
    bus_if.load_req_i = 3'b001; cyc();
    bus_if.load_req_i = 3'b000; bus_if.store_req_i = 1'b1; cyc();
    bus_if.store_req_i = 1'b0; bus_if.load_req_i = 3'b100; cyc();
    idle_inputs();
    bus_if.tcdm_r_valid_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      got = {bus_if.store_r_valid_o, bus_if.load_r_valid_o};
      checks++;
      if (got !== exp_rv[i]) begin errors++; $display("FAIL route[%0d]: got %b expected %b", i, got, exp_rv[i]); end
      cyc();
    end
    @(negedge clk);
    got = {bus_if.store_r_valid_o, bus_if.load_r_valid_o};
    checks++;
    if (got !== 4'b0000 || bus_if.rsp_err_o !== 1'b0) begin
      errors++; $display("FAIL route_extra: got rv=%b err=%b expected rv=0000 err=0", got, bus_if.rsp_err_o);
    end
    cyc();
    bus_if.tcdm_r_valid_i = 1'b0;
    @(negedge clk);
    checks++;
    if (bus_if.rsp_err_o !== 1'b1) begin errors++; $display("FAIL rsp_err_set: got %b expected 1", bus_if.rsp_err_o); end
    cyc();
    do_clear();
    @(negedge clk);
    checks++;
    if (bus_if.rsp_err_o !== 1'b0) begin errors++; $display("FAIL rsp_err_clear: got %b expected 0", bus_if.rsp_err_o); end
    cyc();
  endtask

  task automatic test_reset_locked();
    logic [9:0] outs;
    do_clear();
    bus_if.load_req_i = 3'b001;
    bus_if.tcdm_gnt_i = 1'b1;
    cyc();
    cyc();
    bus_if.tcdm_gnt_i = 1'b0;
    cyc();
    @(negedge clk);
    checks++;
    if (bus_if.busy_o !== 1'b1 || bus_if.tcdm_req_o !== 1'b1) begin
      errors++; $display("FAIL rstlock_pre: got busy=%b req=%b expected 1 1", bus_if.busy_o, bus_if.tcdm_req_o);
    end
    rst_n = 1'b0;
    idle_inputs();
    #1;
    outs = {bus_if.tcdm_req_o, bus_if.tcdm_wen_o, bus_if.sel_o, bus_if.load_gnt_o,
            bus_if.store_gnt_o, bus_if.busy_o, bus_if.rsp_err_o};
    checks++;
    if (outs !== 10'b0) begin errors++; $display("FAIL rstlock_outputs: got %b expected %b", outs, 10'b0); end
    @(posedge clk);
    #1 rst_n = 1'b1;
    bus_if.load_req_i  = 3'b111;
    bus_if.store_req_i = 1'b1;
    bus_if.tcdm_gnt_i  = 1'b1;
    @(negedge clk);
    checks++;
    if (bus_if.sel_o !== 2'd3 || bus_if.store_gnt_o !== 1'b1) begin
      errors++; $display("FAIL rstlock_first_store: got sel=%0d sgnt=%b expected sel=3 sgnt=1", bus_if.sel_o, bus_if.store_gnt_o);
    end
    cyc();
    idle_inputs();
    cyc();
  endtask

  initial begin
    rst_n  = 1'b0;
    clear  = 1'b0;
    enable = 1'b0;
    idle_inputs();
    test_reset();
    test_rr_loads();
    test_class_arb();
    test_lock();
    test_outstanding();
    test_rsp_routing();
    test_reset_locked();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/redmule_ldst_scheduler.md
# redmule_ldst_scheduler

Request-level scheduler for the RedMulE streamer's single shared TCDM port. It sits in place of the two static dynamic muxes between the load sources (X, W, Y) and the store sink (Z) on one side and the TCDM initiator on the other. It arbitrates each transaction, holds the selection stable across HCI grant stalls, and routes in-order responses back to the originating channel through an internal ID FIFO. Data, address and byte-enable buses are steered outside this block by a mux driven by `sel_o`.

## Interface
Parameters:
- `OUTSTANDING`, 4: maximum in-flight TCDM transactions; depth of the response-ID FIFO (power of two, ≥2).
- `NumLoad`, `NumStreamSources` (3): number of load requesters; index order is X=0, W=1, Y=2.

Ports:
- `clk_i`, in, 1: clock.
- `rst_ni`, in, 1: asynchronous active-low reset.
- `clear_i`, in, 1: synchronous soft clear.
- `enable_i`, in, 1: permits new requests.
- `load_req_i`, in, 3: load request, one bit per source.
- `load_gnt_o`, out, 3: load grant.
- `store_req_i`, in, 1: Z store request.
- `store_gnt_o`, out, 1: Z store grant.
- `tcdm_req_o`, out, 1: request to TCDM.
- `tcdm_gnt_i`, in, 1: TCDM grant.
- `tcdm_wen_o`, out, 1: 1 = read (load), 0 = write (store).
- `sel_o`, out, 2: selected channel (0..2 = load id, 3 = store).
- `tcdm_r_valid_i`, in, 1: TCDM response valid.
- `load_r_valid_o`, out, 3: routed response valid, per load.
- `store_r_valid_o`, out, 1: routed write response.
- `busy_o`, out, 1: outstanding count ≠ 0 or a locked request is pending.
- `rsp_err_o`, out, 1: sticky flag; set when a response arrives while the ID FIFO is empty.

## Operation
- Two classes compete: load and store.
- Loads are round-robin among asserted `load_req_i`. The RR pointer advances to granted index+1 only on a load handshake.
- Class arbitration when both classes request: the `last_was_store` bit decides. If it is 1, the load class wins; otherwise the store class wins. The bit updates on every handshake.
- Eligibility: `enable_i`=1 and count < `OUTSTANDING`. Full is checked on the registered count, so a same-cycle pop does not free a slot.
- Lock:
  - When `tcdm_req_o`=1 and `tcdm_gnt_i`=0, the current `sel_o` is registered in `lock_q`.
  - While locked, `tcdm_req_o` stays 1 and `sel_o` is held, regardless of `enable_i` or other requests.
  - The lock releases on `tcdm_gnt_i`.
  - The requester must hold its req while ungranted, per the HCI rule.
- Grant: `load_gnt_o[sel]` or `store_gnt_o` equals `tcdm_gnt_i` AND the channel is selected AND `tcdm_req_o`.
- Handshake (`tcdm_req_o` & `tcdm_gnt_i`) pushes `sel_o` into the ID FIFO.
- `tcdm_r_valid_i` pops the FIFO head and pulses the matching `*_r_valid_o`. Push and pop in the same cycle leave the count unchanged.
- An empty-FIFO response is dropped and sets `rsp_err_o`.
- `clear_i`:
  - Resets the RR pointer, `last_was_store`, lock, FIFO pointers, count and `rsp_err_o`.
  - Responses still in flight after a clear are dropped and flagged.
- States: IDLE (no lock), LOCKED. Transitions:
  - IDLE→LOCKED on req & !gnt.
  - LOCKED→IDLE on gnt or `clear_i`.
  - `rst_ni` low forces IDLE from any state.

## Timing
- Request path is combinational: `load_req_i`/`store_req_i` to `tcdm_req_o`/`sel_o` with 0 cycles.
- Response routing is combinational from `tcdm_r_valid_i` through the registered FIFO head.
- Minimum TCDM response latency is 1 cycle; responses return in order.
- Reset values: all outputs 0; `sel_o`=0; RR pointer=0; `last_was_store`=0; count=0.
- Back-to-back handshakes are allowed every cycle up to the `OUTSTANDING` limit.

## Configuration
- `REDMULE_LDST_SCHED_PERF_EN` defined:
  - Adds 32-bit saturating counters `perf_stall_o` (cycles in LOCKED) and `perf_full_o` (cycles with a pending request blocked by full count).
  - Counters are cleared by `clear_i` and reset to 0.
- Undefined: no counters and no such ports. Arbitration is otherwise identical.

## Structure
- `redmule_pkg`:
  - `ldst_sel_e` (2-bit enum: `SEL_X`, `SEL_W`, `SEL_Y`, `SEL_Z`).
  - `LdstOutstanding` default.
  - Reuses the `XsourceStreamId`/`WsourceStreamId`/`YsourceStreamId` constants.
- Sub-module `redmule_ldst_rsp_fifo`: `OUTSTANDING`-deep, 2-bit-wide circular FIFO with wrap-around pointers, count, and push/pop/full/empty.

## Test plan
- X and Y requests held, gnt always 1 → grants alternate X, Y, X, Y; `sel_o` 0, 2, 0, 2.
- `load_req_i`=3'b111 and store request, gnt=1 → grant sequence Z, X, Z, W, Z, Y.
- W request, gnt low 3 cycles, X asserted in cycle 2 → `sel_o` held at 1 and `tcdm_req_o`=1 throughout; W granted in cycle 4, X granted in cycle 5.
- `OUTSTANDING`=4 with no responses → exactly 4 handshakes, then `tcdm_req_o`=0. One `r_valid` → next request is issued the following cycle.
- Issue X, Z, Y, then 3 `r_valid` → `load_r_valid_o[0]`, `store_r_valid_o`, `load_r_valid_o[2]` in order. An extra `r_valid` sets `rsp_err_o`=1 and no output pulses.
- `rst_ni` asserted while LOCKED with 2 outstanding → all outputs 0 and `busy_o`=0 immediately. After release, the first grant goes to the store when both classes request.
